// File: rtl/isa_pkg.sv
// ISA constants shared by the mul/div issue controller and its datapath:
// opcode/ALU-op encodings, field positions, exception codes and FSM states.
package isa_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  localparam int EXC_REG = 30;
  localparam int EXC_MUL = 4;
  localparam int EXC_DIV = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multdiv_datapath.sv
// Iterative signed mul/div datapath: one radix-2 step per cycle, sign fix and overflow check on the last step.
// No backpressure of its own; result/exc registers hold until the next start.
module multdiv_datapath
  import isa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             finish,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res,
  output logic             exc
);

  localparam int W2 = 2 * WIDTH;

  logic [WIDTH-1:0] mag_b;
  logic [W2-1:0]    acc;
  logic             neg;
  logic             div_sel;

  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_part;
  logic             div_fits;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    acc_next;
  logic [W2-1:0]    mul_signed;
  logic             mul_ovf;
  logic [WIDTH-1:0] quot;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  // Divide: acc = {partial remainder, remaining dividend bits / quotient bits}, shifted left.
  always_comb begin
    mul_sum    = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next   = {mul_sum, acc[WIDTH-1:1]};
    div_part   = acc[W2-1:WIDTH-1];
    div_fits   = div_part >= {1'b0, mag_b};
    div_sub    = div_part[WIDTH-1:0] - mag_b;
    div_rem    = div_fits ? div_sub : div_part[WIDTH-1:0];
    div_next   = {div_rem, acc[WIDTH-2:0], div_fits};
    acc_next   = div_sel ? div_next : mul_next;
    mul_signed = neg ? -acc_next : acc_next;
    mul_ovf    = mul_signed[W2-1:WIDTH] != {WIDTH{mul_signed[WIDTH-1]}};
    quot       = neg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag_b   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      div_sel <= 1'b0;
      res     <= '0;
      exc     <= 1'b0;
    end else if (start) begin
      mag_b   <= magnitude(op_b);
      acc     <= {{WIDTH{1'b0}}, magnitude(op_a)};
      neg     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      div_sel <= is_div;
      if (is_div && op_b == '0) begin
        res <= WIDTH'(EXC_DIV);
        exc <= 1'b1;
      end else begin
        res <= '0;
        exc <= 1'b0;
      end
    end else if (step) begin
      acc <= acc_next;
      if (finish) begin
        if (!div_sel && mul_ovf) begin
          res <= WIDTH'(EXC_MUL);
          exc <= 1'b1;
        end else begin
          res <= div_sel ? quot : mul_signed[WIDTH-1:0];
          exc <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Mul/div issue control: latches the X-stage op, runs ITERS cycles (div-by-zero finishes at once), busy until writeback.
// Result held on wb_* while wb_valid && !wb_ready; no new issue until the cycle after the handshake.
module multdiv_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ITERS   = 32,
  parameter int EXC_REG = isa_pkg::EXC_REG
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [31:0]      dx_insn,
  input  logic [WIDTH-1:0] dx_opA,
  input  logic [WIDTH-1:0] dx_opB,
  output logic             multOngoing,
  output logic [31:0]      inM,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_exc
);

  import isa_pkg::*;

  state_t      state;
  state_t      state_n;
  logic [5:0]  cnt;
  logic        is_muldiv;
  logic        is_div;
  logic        div_zero;
  logic        issue;
  logic        last_iter;
  logic        handshake;
  logic        dp_exc;

  always_comb begin
    is_div    = dx_insn[ALU_HI:ALU_LO] == ALU_DIV;
    is_muldiv = (dx_insn[OPC_HI:OPC_LO] == OP_RTYPE) &&
                (dx_insn[ALU_HI:ALU_LO] == ALU_MUL || is_div);
    div_zero  = is_div && dx_opB == '0;
    issue     = issue_valid && is_muldiv && state == ST_IDLE;
    last_iter = state == ST_RUN && cnt == 6'(ITERS - 1);
    handshake = state == ST_DONE && wb_ready;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (issue)     state_n = div_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_iter) state_n = ST_DONE;
      ST_DONE: if (wb_ready)  state_n = ST_IDLE;
      default:                state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      inM   <= '0;
    end else begin
      state <= state_n;
      if (issue) begin
        cnt <= '0;
        inM <= dx_insn;
      end else begin
        if (state == ST_RUN) cnt <= cnt + 6'd1;
        // inM doubles as the stall logic's noop when the unit is free.
        if (handshake) inM <= '0;
      end
    end
  end

  multdiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock  (clock),
    .reset  (reset),
    .start  (issue),
    .step   (state == ST_RUN),
    .finish (last_iter),
    .is_div (is_div),
    .op_a   (dx_opA),
    .op_b   (dx_opB),
    .res    (wb_data),
    .exc    (dp_exc)
  );

  assign multOngoing = state != ST_IDLE;
  assign wb_valid    = state == ST_DONE;
  assign wb_exc      = dp_exc;
  assign wb_rd       = dp_exc ? 5'(EXC_REG) : inM[RD_HI:RD_LO];

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed vector bench for multdiv_issue_ctrl: table of mul/div ops plus
// hand sequences for writeback backpressure and mid-operation reset.
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [31:0] dx_insn;
  logic [31:0] dx_opA;
  logic [31:0] dx_opB;
  logic        multOngoing;
  logic [31:0] inM;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multdiv_issue_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .dx_insn     (dx_insn),
    .dx_opA      (dx_opA),
    .dx_opB      (dx_opB),
    .multOngoing (multOngoing),
    .inM         (inM),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_exc      (wb_exc)
  );

  typedef struct {
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_exc;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic div, input logic [4:0] rd);
    logic [4:0] alu;
    alu = div ? 5'b00111 : 5'b00110;
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
  endfunction

  // Presents one op for exactly one rising edge (edge 0).
  task automatic issue_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    issue_valid = 1'b1;
    dx_insn     = insn;
    dx_opA      = a;
    dx_opB      = b;
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    dx_insn     = 32'h0;
    dx_opA      = 32'h0;
    dx_opB      = 32'h0;
  endtask

  // Called just after edge 0; returns the cycle number in which wb_valid is first seen.
  task automatic wait_valid(input string name, input logic [31:0] insn, output int lat);
    logic busy_ok;
    @(negedge clock);
    check({name, " busy c1"}, {31'b0, multOngoing}, 32'd1);
    check({name, " inM c1"}, inM, insn);
    lat = 1;
    busy_ok = 1'b1;
    while (!wb_valid && lat < 200) begin
      @(negedge clock);
      lat++;
      busy_ok = busy_ok & multOngoing & (inM == insn);
    end
    check({name, " busy/inM held"}, {31'b0, busy_ok}, 32'd1);
  endtask

  task automatic run_op(input string name, input vec_t v);
    logic [31:0] insn;
    int lat;
    insn = mk_insn(v.div, v.rd);
    wb_ready = 1'b1;
    issue_op(insn, v.a, v.b);
    wait_valid(name, insn, lat);
    check({name, " latency"}, lat, v.exp_lat);
    check({name, " wb_rd"}, {27'b0, wb_rd}, {27'b0, v.exp_rd});
    check({name, " wb_data"}, wb_data, v.exp_data);
    check({name, " wb_exc"}, {31'b0, wb_exc}, {31'b0, v.exp_exc});
    @(negedge clock);
    check({name, " post busy"}, {31'b0, multOngoing}, 32'd0);
    check({name, " post inM"}, inM, 32'd0);
    check({name, " post valid"}, {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] insn2;
    int lat;

    vecs.push_back('{1'b0, 32'd7,        32'hFFFFFFFD, 5'd5, 5'd5,  32'hFFFFFFEB, 1'b0, 33});
    vecs.push_back('{1'b1, 32'hFFFFFF9C, 32'd7,        5'd9, 5'd9,  32'hFFFFFFF2, 1'b0, 33});
    vecs.push_back('{1'b1, 32'd5,        32'd0,        5'd3, 5'd30, 32'd5,        1'b1, 1});
    vecs.push_back('{1'b0, 32'h00010000, 32'h00010000, 5'd4, 5'd30, 32'd4,        1'b1, 33});
    vecs.push_back('{1'b0, 32'h80000000, 32'd1,        5'd6, 5'd6,  32'h80000000, 1'b0, 33});
    vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd7, 5'd7,  32'h80000000, 1'b0, 33});
    vecs.push_back('{1'b1, 32'd7,        32'hFFFFFFFE, 5'd8, 5'd8,  32'hFFFFFFFD, 1'b0, 33});
    vecs.push_back('{1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd1, 5'd1,  32'h80000001, 1'b0, 33});
    vecs.push_back('{1'b0, 32'd0,        32'hFFFFFFFB, 5'd0, 5'd0,  32'd0,        1'b0, 33});
    vecs.push_back('{1'b0, 32'hFFFF0000, 32'h00008000, 5'd2, 5'd2,  32'h80000000, 1'b0, 33});
    vecs.push_back('{1'b0, 32'h00010000, 32'h00008000, 5'd2, 5'd30, 32'd4,        1'b1, 33});
    vecs.push_back('{1'b1, 32'd100,      32'd10,       5'd31, 5'd31, 32'd10,      1'b0, 33});

    reset       = 1'b1;
    issue_valid = 1'b0;
    dx_insn     = 32'h0;
    dx_opA      = 32'h0;
    dx_opB      = 32'h0;
    wb_ready    = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset busy", {31'b0, multOngoing}, 32'd0);
    check("reset inM", inM, 32'd0);
    check("reset valid", {31'b0, wb_valid}, 32'd0);
    check("reset rd", {27'b0, wb_rd}, 32'd0);
    check("reset data", wb_data, 32'd0);
    check("reset exc", {31'b0, wb_exc}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held 5 cycles, handshake on the 6th, same-cycle reissue ignored.
    wb_ready = 1'b0;
    issue_op(mk_insn(1'b0, 5'd2), 32'd3, 32'd4);
    wait_valid("bp", mk_insn(1'b0, 5'd2), lat);
    check("bp latency", lat, 33);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("bp hold%0d valid", k), {31'b0, wb_valid}, 32'd1);
      check($sformatf("bp hold%0d data", k), wb_data, 32'd12);
      check($sformatf("bp hold%0d rd", k), {27'b0, wb_rd}, 32'd2);
      check($sformatf("bp hold%0d busy", k), {31'b0, multOngoing}, 32'd1);
    end
    insn2 = mk_insn(1'b0, 5'd3);
    wb_ready    = 1'b1;
    issue_valid = 1'b1;
    dx_insn     = insn2;
    dx_opA      = 32'd5;
    dx_opB      = 32'd5;
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    dx_insn     = 32'h0;
    @(negedge clock);
    check("bp hs busy", {31'b0, multOngoing}, 32'd0);
    check("bp hs inM", inM, 32'd0);
    check("bp hs valid", {31'b0, wb_valid}, 32'd0);
    issue_op(insn2, 32'd5, 32'd5);
    wait_valid("bp reissue", insn2, lat);
    check("bp reissue latency", lat, 33);
    check("bp reissue data", wb_data, 32'd25);
    check("bp reissue rd", {27'b0, wb_rd}, 32'd3);

    // Reset between edges in the middle of RUN.
    @(negedge clock);
    issue_op(mk_insn(1'b0, 5'd4), 32'd100, 32'd100);
    repeat (9) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("rst busy", {31'b0, multOngoing}, 32'd0);
    check("rst inM", inM, 32'd0);
    check("rst valid", {31'b0, wb_valid}, 32'd0);
    check("rst data", wb_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    v = '{1'b0, 32'd6, 32'd6, 5'd11, 5'd11, 32'd36, 1'b0, 33};
    run_op("after rst", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
